// File: rtl/syscsr_axi_pkg.sv
// Shared constants, FSM state types and address helper for the system CSR AXI responder.
package syscsr_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] SIZE_128B = 4'd4;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

  // Addresses are tracked as 16-byte block numbers; the bank base is DEPTH-aligned,
  // so an unsigned offset below depth is exactly the in-range window.
  function automatic logic blk_in_range(input logic [27:0] blk,
                                        input logic [27:0] base_blk,
                                        input int unsigned depth);
    logic [27:0] off;
    off = blk - base_blk;
    return off < 28'(depth);
  endfunction

endpackage

// File: rtl/syscsr_regbank.sv
// DEPTH x 128-bit register bank: byte-strobed write port, combinational read port,
// contents exported as one flat bus.
module syscsr_regbank #(
  parameter int DEPTH = 4,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IDXW-1:0]        wr_idx,
  input  logic [127:0]           wr_data,
  input  logic [15:0]            wr_strb,
  input  logic [IDXW-1:0]        rd_idx,
  output logic [127:0]           rd_data,
  output logic [DEPTH*128-1:0]   csr_q
);

  logic [127:0] mem_q [DEPTH];
  logic [127:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int b = 0; b < 16; b++) begin
        if (wr_strb[b]) mem_d[wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
      end
    end
  end

  // NOTE: this bank is a handful of control registers, not a RAM macro, so it is
  // cleared by reset like any other flop; a real memory array would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: sequential state always takes <=, so every flop samples pre-edge values.
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_idx];

  always_comb begin
    csr_q = '0;
    for (int i = 0; i < DEPTH; i++) csr_q[i*128 +: 128] = mem_q[i];
  end

endmodule

// File: rtl/syscsr_axi_slv.sv
// AXI responder for the system CSR port: independent single-outstanding write and read
// burst FSMs serving a local bank of 128-bit registers.
module syscsr_axi_slv
  import syscsr_axi_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 syscsr_slv_ACLK,
  input  logic                 syscsr_slv_ARESETn,
  input  logic [31:0]          syscsr_slv_AWADDR,
  input  logic [7:0]           syscsr_slv_AWID,
  input  logic                 syscsr_slv_AWVALID,
  input  logic [3:0]           syscsr_slv_AWSIZE,
  input  logic [3:0]           syscsr_slv_AWLEN,
  output logic                 syscsr_slv_AWREADY,
  input  logic [127:0]         syscsr_slv_WDATA,
  input  logic [15:0]          syscsr_slv_WSTRB,
  input  logic                 syscsr_slv_WLAST,
  input  logic                 syscsr_slv_WVALID,
  output logic                 syscsr_slv_WREADY,
  output logic [7:0]           syscsr_slv_BID,
  output logic [1:0]           syscsr_slv_BRESP,
  output logic                 syscsr_slv_BVALID,
  input  logic                 syscsr_slv_BREADY,
  input  logic [31:0]          syscsr_slv_ARADDR,
  input  logic [7:0]           syscsr_slv_ARID,
  input  logic                 syscsr_slv_ARVALID,
  input  logic [3:0]           syscsr_slv_ARSIZE,
  input  logic [3:0]           syscsr_slv_ARLEN,
  output logic                 syscsr_slv_ARREADY,
  output logic [7:0]           syscsr_slv_RID,
  output logic [127:0]         syscsr_slv_RDATA,
  output logic [1:0]           syscsr_slv_RRESP,
  output logic                 syscsr_slv_RLAST,
  output logic                 syscsr_slv_RVALID,
  input  logic                 syscsr_slv_RREADY,
  output logic [DEPTH*128-1:0] csr_q,
  output logic                 csr_err
);

  localparam int          IDXW     = $clog2(DEPTH);
  localparam logic [27:0] BASE_BLK = BASE_ADDR[31:4];

  logic clk, rst_n;
  assign clk   = syscsr_slv_ACLK;
  assign rst_n = syscsr_slv_ARESETn;

  // Write path state
  wr_state_e   wr_state_q, wr_state_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [7:0]  bid_q, bid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [27:0] wblk_q, wblk_d;
  logic [3:0]  wlen_q, wlen_d, wsize_q, wsize_d, wbeat_q, wbeat_d;
  logic        wdec_q, wdec_d, wslv_q, wslv_d;

  // Read path state
  rd_state_e    rd_state_q, rd_state_d;
  logic         arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [7:0]   rid_q, rid_d;
  logic [127:0] rdata_q, rdata_d;
  logic [1:0]   rresp_q, rresp_d;
  logic [27:0]  rblk_q, rblk_d;
  logic [3:0]   rlen_q, rlen_d, rsize_q, rsize_d, rbeat_q, rbeat_d;
  logic         rerr_q, rerr_d;
  logic         csr_err_q, csr_err_d;

  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic          w_oor, w_last_beat, w_slv_now, bank_we;
  logic [27:0]   wr_off, rd_off, ld_blk;
  logic [3:0]    ld_size, ld_beat;
  logic          load, ld_in;
  logic [127:0]  bank_rd;

  assign aw_hs = syscsr_slv_AWVALID & awready_q;
  assign w_hs  = syscsr_slv_WVALID  & wready_q;
  assign b_hs  = bvalid_q & syscsr_slv_BREADY;
  assign ar_hs = syscsr_slv_ARVALID & arready_q;
  assign r_hs  = rvalid_q & syscsr_slv_RREADY;

  assign wr_off      = wblk_q - BASE_BLK;
  assign w_oor       = !blk_in_range(wblk_q, BASE_BLK, DEPTH);
  assign w_last_beat = (wbeat_q == wlen_q);
  assign w_slv_now   = (wsize_q != SIZE_128B) || (syscsr_slv_WLAST != w_last_beat);

  // NOTE: every always_comb starts from a full set of defaults so no path can infer a latch.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    wblk_d     = wblk_q;
    wlen_d     = wlen_q;
    wsize_d    = wsize_q;
    wbeat_d    = wbeat_q;
    wdec_d     = wdec_q;
    wslv_d     = wslv_q;
    bank_we    = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          bid_d      = syscsr_slv_AWID;
          wblk_d     = syscsr_slv_AWADDR[31:4];
          wlen_d     = syscsr_slv_AWLEN;
          wsize_d    = syscsr_slv_AWSIZE;
          wbeat_d    = '0;
          wdec_d     = 1'b0;
          wslv_d     = 1'b0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          bank_we = !w_oor && (wsize_q == SIZE_128B);
          wblk_d  = wblk_q + 28'd1;
          wbeat_d = wbeat_q + 4'd1;
          wdec_d  = wdec_q | w_oor;
          wslv_d  = wslv_q | w_slv_now;
          // The burst ends on the beat count; WLAST only feeds the error flag.
          if (w_last_beat) begin
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = (wdec_q | w_oor)     ? RESP_DECERR :
                         (wslv_q | w_slv_now) ? RESP_SLVERR : RESP_OKAY;
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (b_hs) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rblk_d     = rblk_q;
    rlen_d     = rlen_q;
    rsize_d    = rsize_q;
    rbeat_d    = rbeat_q;
    rerr_d     = rerr_q;
    load       = 1'b0;
    ld_blk     = rblk_q + 28'd1;
    ld_size    = rsize_q;
    ld_beat    = rbeat_q + 4'd1;
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rid_d      = syscsr_slv_ARID;
          rlen_d     = syscsr_slv_ARLEN;
          rsize_d    = syscsr_slv_ARSIZE;
          rerr_d     = 1'b0;
          load       = 1'b1;
          ld_blk     = syscsr_slv_ARADDR[31:4];
          ld_size    = syscsr_slv_ARSIZE;
          ld_beat    = '0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          rerr_d = rerr_q | (rresp_q != RESP_OKAY);
          if (rlast_q) begin
            rvalid_d   = 1'b0;
            rlast_d    = 1'b0;
            arready_d  = 1'b1;
            rd_state_d = R_IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    // Read data is sampled from the bank before any same-cycle write lands.
    if (load) begin
      rblk_d  = ld_blk;
      rbeat_d = ld_beat;
      rdata_d = ld_in ? bank_rd : '0;
      rresp_d = !ld_in                 ? RESP_DECERR :
                (ld_size != SIZE_128B) ? RESP_SLVERR : RESP_OKAY;
      rlast_d = (ld_beat == rlen_d);
    end
  end

  assign rd_off = ld_blk - BASE_BLK;
  assign ld_in  = blk_in_range(ld_blk, BASE_BLK, DEPTH);

  always_comb begin
    csr_err_d = (b_hs && (bresp_q != RESP_OKAY)) ||
                (r_hs && rlast_q && (rerr_q || (rresp_q != RESP_OKAY)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
      wblk_q     <= '0;
      wlen_q     <= '0;
      wsize_q    <= '0;
      wbeat_q    <= '0;
      wdec_q     <= 1'b0;
      wslv_q     <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      wblk_q     <= wblk_d;
      wlen_q     <= wlen_d;
      wsize_q    <= wsize_d;
      wbeat_q    <= wbeat_d;
      wdec_q     <= wdec_d;
      wslv_q     <= wslv_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rblk_q     <= '0;
      rlen_q     <= '0;
      rsize_q    <= '0;
      rbeat_q    <= '0;
      rerr_q     <= 1'b0;
      csr_err_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rblk_q     <= rblk_d;
      rlen_q     <= rlen_d;
      rsize_q    <= rsize_d;
      rbeat_q    <= rbeat_d;
      rerr_q     <= rerr_d;
      csr_err_q  <= csr_err_d;
    end
  end

  syscsr_regbank #(.DEPTH(DEPTH), .IDXW(IDXW)) u_regbank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bank_we),
    .wr_idx  (wr_off[IDXW-1:0]),
    .wr_data (syscsr_slv_WDATA),
    .wr_strb (syscsr_slv_WSTRB),
    .rd_idx  (rd_off[IDXW-1:0]),
    .rd_data (bank_rd),
    .csr_q   (csr_q)
  );

  logic unused_bits;
  assign unused_bits = ^{syscsr_slv_AWADDR[3:0], syscsr_slv_ARADDR[3:0],
                         wr_off[27:IDXW], rd_off[27:IDXW]};

  assign syscsr_slv_AWREADY = awready_q;
  assign syscsr_slv_WREADY  = wready_q;
  assign syscsr_slv_BVALID  = bvalid_q;
  assign syscsr_slv_BID     = bid_q;
  assign syscsr_slv_BRESP   = bresp_q;
  assign syscsr_slv_ARREADY = arready_q;
  assign syscsr_slv_RVALID  = rvalid_q;
  assign syscsr_slv_RID     = rid_q;
  assign syscsr_slv_RDATA   = rdata_q;
  assign syscsr_slv_RRESP   = rresp_q;
  assign syscsr_slv_RLAST   = rlast_q;
  assign csr_err            = csr_err_q;

endmodule

// File: tb/tb_syscsr_axi_slv.sv
// Randomized self-checking bench for syscsr_axi_slv against an array-based register model.
module tb_syscsr_axi_slv;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] aw_addr, ar_addr;
  logic [7:0]  aw_id, ar_id, bid, rid;
  logic        aw_valid, ar_valid, awready, arready;
  logic [3:0]  aw_size, aw_len, ar_size, ar_len;
  logic [127:0] w_data, rdata;
  logic [15:0] w_strb;
  logic        w_last, w_valid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, b_ready, rlast, rvalid, r_ready;
  logic [DEPTH*128-1:0] csr_q;
  logic        csr_err;

  logic [127:0] model [DEPTH];
  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  int err_exp  = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (csr_err === 1'b1) err_cnt++;

  syscsr_axi_slv #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .syscsr_slv_ACLK(clk),        .syscsr_slv_ARESETn(rst_n),
    .syscsr_slv_AWADDR(aw_addr),  .syscsr_slv_AWID(aw_id),     .syscsr_slv_AWVALID(aw_valid),
    .syscsr_slv_AWSIZE(aw_size),  .syscsr_slv_AWLEN(aw_len),   .syscsr_slv_AWREADY(awready),
    .syscsr_slv_WDATA(w_data),    .syscsr_slv_WSTRB(w_strb),   .syscsr_slv_WLAST(w_last),
    .syscsr_slv_WVALID(w_valid),  .syscsr_slv_WREADY(wready),
    .syscsr_slv_BID(bid),         .syscsr_slv_BRESP(bresp),    .syscsr_slv_BVALID(bvalid),
    .syscsr_slv_BREADY(b_ready),
    .syscsr_slv_ARADDR(ar_addr),  .syscsr_slv_ARID(ar_id),     .syscsr_slv_ARVALID(ar_valid),
    .syscsr_slv_ARSIZE(ar_size),  .syscsr_slv_ARLEN(ar_len),   .syscsr_slv_ARREADY(arready),
    .syscsr_slv_RID(rid),         .syscsr_slv_RDATA(rdata),    .syscsr_slv_RRESP(rresp),
    .syscsr_slv_RLAST(rlast),     .syscsr_slv_RVALID(rvalid),  .syscsr_slv_RREADY(r_ready),
    .csr_q(csr_q),                .csr_err(csr_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + DEPTH * 16);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - BASE) >> 4);
  endfunction

  function automatic logic pick(input int sel);
    case (sel)
      0:       return awready;
      1:       return wready;
      2:       return bvalid;
      3:       return arready;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag);
    int n = 0;
    while (pick(sel) !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check({tag, "_timeout"}, 128'd0, 128'd1);
  endtask

  task automatic check_csr(input string tag);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("%s_csr%0d", tag, i), csr_q[i*128 +: 128], model[i]);
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] size,
                          input logic [7:0] id, input bit early_last, input bit rnd,
                          input logic [127:0] d0, input logic [15:0] s0, input int bdelay);
    bit dec = 0;
    bit slv = (size != 4'd4);
    logic [1:0] exp_resp;
    logic [31:0] a;
    aw_addr = addr; aw_id = id; aw_len = 4'(len); aw_size = size; aw_valid = 1'b1;
    wait_for(0, "awready");
    @(posedge clk); #1;
    aw_valid = 1'b0;
    check("aw_accept_awready", awready, 1'b0);
    check("aw_accept_wready", wready, 1'b1);
    for (int b = 0; b <= len; b++) begin
      w_data  = rnd ? {$urandom, $urandom, $urandom, $urandom} : d0 + 128'(b);
      w_strb  = rnd ? 16'($urandom) : s0;
      w_last  = early_last ? (b == 0) : (b == len);
      w_valid = 1'b1;
      wait_for(1, "wready");
      @(posedge clk); #1;
      a = addr + 32'(b) * 32'd16;
      if (w_last != (b == len)) slv = 1;
      if (!in_rng(a)) dec = 1;
      else if (size == 4'd4) begin
        for (int k = 0; k < 16; k++)
          if (w_strb[k]) model[idx_of(a)][k*8 +: 8] = w_data[k*8 +: 8];
      end
      if (in_rng(a))
        check("w_beat_csr", csr_q[idx_of(a)*128 +: 128], model[idx_of(a)]);
    end
    w_valid = 1'b0; w_last = 1'b0;
    exp_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    check("bvalid_after_last", bvalid, 1'b1);
    check("wready_after_last", wready, 1'b0);
    check("bresp", bresp, exp_resp);
    check("bid", bid, id);
    if (bdelay > 0) begin
      repeat (bdelay) @(posedge clk);
      #1;
      check("bvalid_hold", bvalid, 1'b1);
      check("bresp_hold", bresp, exp_resp);
    end
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
    check("awready_after_b", awready, 1'b1);
    check("bvalid_after_b", bvalid, 1'b0);
    if (exp_resp != 2'b00) err_exp++;
    @(posedge clk); #1;
    check("csr_err_count_w", err_cnt, err_exp);
    check_csr("after_w");
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] size,
                         input logic [7:0] id);
    bit any_err = 0;
    logic [31:0] a;
    logic [127:0] exp_data;
    logic [1:0] exp_resp;
    ar_addr = addr; ar_id = id; ar_len = 4'(len); ar_size = size; ar_valid = 1'b1;
    wait_for(3, "arready");
    @(posedge clk); #1;
    ar_valid = 1'b0;
    check("ar_accept_arready", arready, 1'b0);
    check("rvalid_next_cycle", rvalid, 1'b1);
    for (int b = 0; b <= len; b++) begin
      wait_for(4, "rvalid");
      a = addr + 32'(b) * 32'd16;
      exp_data = in_rng(a) ? model[idx_of(a)] : 128'd0;
      exp_resp = !in_rng(a) ? 2'b11 : (size != 4'd4 ? 2'b10 : 2'b00);
      check("rdata", rdata, exp_data);
      check("rresp", rresp, exp_resp);
      check("rlast", rlast, b == len);
      check("rid", rid, id);
      if ($urandom_range(0, 1) == 1) begin
        r_ready = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
        check("rdata_hold", rdata, exp_data);
        check("rresp_hold", rresp, exp_resp);
      end
      r_ready = 1'b1;
      @(posedge clk); #1;
      r_ready = 1'b0;
      if (exp_resp != 2'b00) any_err = 1;
    end
    check("arready_after_r", arready, 1'b1);
    check("rvalid_after_r", rvalid, 1'b0);
    if (any_err) err_exp++;
    @(posedge clk); #1;
    check("csr_err_count_r", err_cnt, err_exp);
  endtask

  initial begin
    int k;
    logic [31:0] addr;
    rst_n = 1'b0;
    aw_addr = '0; aw_id = '0; aw_valid = 1'b0; aw_size = '0; aw_len = '0;
    ar_addr = '0; ar_id = '0; ar_valid = 1'b0; ar_size = '0; ar_len = '0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
    b_ready = 1'b0; r_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", awready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_bid_bresp", {bid, bresp}, 10'd0);
    check("rst_rid_rresp_rlast", {rid, rresp, rlast}, 11'd0);
    check("rst_rdata", rdata, 128'd0);
    check("rst_csr_err", csr_err, 1'b0);
    check_csr("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("awready_rise", awready, 1'b1);
    check("arready_rise", arready, 1'b1);

    // AW and AR to register 2 in the same cycle: read sees the old value.
    aw_addr = BASE + 32'h20; aw_id = 8'h11; aw_len = 4'd0; aw_size = 4'd4; aw_valid = 1'b1;
    ar_addr = BASE + 32'h20; ar_id = 8'h22; ar_len = 4'd0; ar_size = 4'd4; ar_valid = 1'b1;
    @(posedge clk); #1;
    aw_valid = 1'b0; ar_valid = 1'b0;
    check("sim_rvalid", rvalid, 1'b1);
    check("sim_wready", wready, 1'b1);
    check("sim_rdata_old", rdata, 128'd0);
    w_data = 128'd1; w_strb = 16'hFFFF; w_last = 1'b1; w_valid = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0;
    model[2] = 128'd1;
    check("sim_rdata_still_old", rdata, 128'd0);
    check("sim_write_landed", csr_q[2*128 +: 128], 128'd1);
    check("sim_bresp", bresp, 2'b00);
    r_ready = 1'b1; b_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0; b_ready = 1'b0;
    check("sim_idle_both", {awready, arready, bvalid, rvalid}, 4'b1100);
    do_read(BASE + 32'h20, 0, 4'd4, 8'h23);

    // Directed cases
    do_write(BASE + 32'h10, 0, 4'd4, 8'h3C, 0, 0, {16{8'hA5}}, 16'h00FF, 1);
    check("t1_reg1", csr_q[1*128 +: 128], {64'd0, {8{8'hA5}}});
    do_write(BASE, 3, 4'd4, 8'h40, 0, 0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6600,
             16'hFFFF, 0);
    do_read(BASE, 3, 4'd4, 8'h41);
    do_write(BASE + 32'(DEPTH - 1) * 32'd16, 1, 4'd4, 8'h50, 0, 1, '0, '0, 2);
    do_read(BASE, 1, 4'd2, 8'h60);
    do_write(BASE + 32'h10, 1, 4'd4, 8'h70, 1, 1, '0, '0, 0);
    do_read(BASE + 32'(DEPTH - 1) * 32'd16, 1, 4'd4, 8'h71);
    do_read(BASE - 32'd16, 0, 4'd4, 8'h72);

    // Randomized traffic, including out-of-range, bad size, early WLAST and long bursts
    for (int t = 0; t < 40; t++) begin
      k = int'($urandom_range(0, DEPTH + 1)) - 1;
      addr = BASE + 32'(k * 16) + 32'($urandom_range(0, 15) == 0 ? $urandom_range(1, 15) : 0);
      if ($urandom_range(0, 1) == 1)
        do_write(addr, $urandom_range(0, 7) == 0 ? int'($urandom_range(4, 15)) :
                       int'($urandom_range(0, 3)),
                 $urandom_range(0, 5) == 0 ? 4'd3 : 4'd4, 8'($urandom),
                 $urandom_range(0, 7) == 0, 1, '0, '0, int'($urandom_range(0, 2)));
      else
        do_read(addr, $urandom_range(0, 7) == 0 ? int'($urandom_range(4, 15)) :
                      int'($urandom_range(0, 3)),
                $urandom_range(0, 5) == 0 ? 4'd2 : 4'd4, 8'($urandom));
    end

    // Reset in the middle of a write burst
    aw_addr = BASE; aw_id = 8'h90; aw_len = 4'd3; aw_size = 4'd4; aw_valid = 1'b1;
    wait_for(0, "awready");
    @(posedge clk); #1;
    aw_valid = 1'b0;
    w_data = {4{32'hDEAD_BEEF}}; w_strb = 16'hFFFF; w_last = 1'b0; w_valid = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0;
    check("mid_burst_wready", wready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_ready_valid", {awready, wready, bvalid, arready, rvalid}, 5'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    check_csr("mrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_write(BASE + 32'h30, 0, 4'd4, 8'h91, 0, 1, '0, '0, 0);
    do_read(BASE + 32'h30, 0, 4'd4, 8'h92);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/syscsr_axi_slv.md
# syscsr_axi_slv

AXI responder for the system CSR port: accepts AXI write and read bursts on the `syscsr_slv_*` interface and serves them from a local bank of 128-bit control/status registers. It is the slave-side counterpart of the core's AXI master port and sits between the interconnect and system control logic. The bank contents are exported as a flat bus, and an error pulse flags rejected accesses.

## Interface
- `DEPTH`, 4: number of 128-bit registers; power of two, 2..16.
- `BASE_ADDR`, 32'h0000_0000: byte base of the bank; must be aligned to DEPTH*16.
- `syscsr_slv_ACLK`  in  1  clock
- `syscsr_slv_ARESETn`  in  1  asynchronous active-low reset
- `syscsr_slv_AW{ADDR,ID,VALID,SIZE,LEN}`  in  32/8/1/4/4  write address; `syscsr_slv_AWREADY` out 1
- `syscsr_slv_W{DATA,STRB,LAST,VALID}`  in  128/16/1/1  write data; `syscsr_slv_WREADY` out 1
- `syscsr_slv_B{ID,RESP,VALID}`  out  8/2/1  write response; `syscsr_slv_BREADY` in 1
- `syscsr_slv_AR{ADDR,ID,VALID,SIZE,LEN}`  in  32/8/1/4/4  read address; `syscsr_slv_ARREADY` out 1
- `syscsr_slv_R{ID,DATA,RESP,LAST,VALID}`  out  8/128/2/1/1  read data; `syscsr_slv_RREADY` in 1
- `csr_q`  out  DEPTH*128  register contents, reg i at [i*128 +: 128]
- `csr_err`  out  1  one-cycle pulse per burst completed with non-OKAY response

## Operation
- Write and read paths are independent FSMs, each with one outstanding burst; bursts are INCR only, and each beat advances the address by 16 bytes.
- Register index: (addr - BASE_ADDR) >> 4. A beat whose address is outside [BASE_ADDR, BASE_ADDR + DEPTH*16) is out of range.
- Write FSM:
  - W_IDLE (AWREADY=1): on the AW handshake, capture ID, ADDR[31:4], LEN and SIZE; clear the beat counter and error flags; go to W_DATA.
  - W_DATA (WREADY=1): each handshake writes the bytes with STRB=1 into the addressed register. The beat is not written if it is out of range or SIZE≠4. At beat count == LEN, go to W_RESP.
  - W_RESP (BVALID=1): hold BID/BRESP stable until BREADY, then go to W_IDLE.
- BRESP priority: DECERR (2'b11) if any beat was out of range; else SLVERR (2'b10) if SIZE≠4 or WLAST≠(beat==LEN) on any beat; else OKAY. Termination uses the beat count only, never WLAST.
- Read FSM:
  - R_IDLE (ARREADY=1): on the AR handshake, capture ID, ADDR, LEN and SIZE; go to R_DATA.
  - R_DATA (RVALID=1): RDATA = addressed register. RDATA is zero with RRESP DECERR if the beat is out of range; RRESP is SLVERR if SIZE≠4, else OKAY. RLAST=1 when beat == LEN. The next beat is presented on each handshake; after the last handshake, go to R_IDLE.
- Per-beat RRESP is evaluated independently for each beat.
- `csr_err` pulses on the B handshake with non-OKAY BRESP, and on the last R handshake of a burst in which any beat was non-OKAY. If both occur in the same cycle, it is a single pulse.
- Read and write of the same register in the same cycle: the read returns the pre-write value, and the write lands.
- Reset mid-burst: both FSMs return to IDLE, the burst is abandoned with no response, and registers clear.

## Timing
- Reset values:
  - All registers and `csr_q` = 0.
  - AWREADY, ARREADY, WREADY, BVALID and RVALID = 0.
  - BID, BRESP, RID, RDATA and RRESP = 0; RLAST = 0; `csr_err` = 0.
- AWREADY and ARREADY rise in the first cycle after reset release.
- All outputs are registered.
- Write path:
  - AW handshake in cycle N: AWREADY=0 and WREADY=1 from N+1.
  - Last W handshake in cycle M: WREADY=0 and BVALID=1 at M+1.
  - B handshake in cycle K: AWREADY=1 at K+1.
  - A single-beat write therefore takes at least 3 cycles of AW→B.
- `csr_q` reflects a W beat in the cycle after its handshake.
- Read path:
  - AR handshake in cycle N: RVALID=1 with beat 0 at N+1.
  - With RREADY held high, one beat per cycle.
  - Last R handshake in cycle K: ARREADY=1 at K+1.
- R and B outputs hold stable while VALID && !READY.

## Structure
- Package `syscsr_axi_pkg`:
  - RESP_OKAY, RESP_SLVERR and RESP_DECERR;
  - SIZE_128B = 4;
  - write FSM enum (W_IDLE, W_DATA, W_RESP) and read FSM enum (R_IDLE, R_DATA).
- One natural sub-module, `syscsr_regbank`: DEPTH×128 storage with a byte-strobe write port, a combinational read port and the flat `csr_q` output. The AXI FSMs stay in the top module.

## Test plan
- Single write to BASE+0x10, LEN=0, SIZE=4, WDATA=128'hA5.., STRB=16'h00FF, WLAST=1 -> reg1 low 8 bytes = A5, high bytes 0; BRESP=OKAY with BID=AWID; AWREADY=1 one cycle after BREADY.
- Write burst LEN=3 from BASE+0x00 with 4 distinct words, then read burst LEN=3 from the same address with RREADY toggling -> RDATA matches in order, RLAST only on beat 3, RRESP=OKAY.
- Write burst LEN=1 from BASE+(DEPTH-1)*16 -> the first beat is written, the second is dropped; BRESP=DECERR and `csr_err` pulses once.
- Read with SIZE=2 -> RRESP=SLVERR on every beat; write with WLAST asserted on beat 0 of LEN=1 -> both beats are written, BRESP=SLVERR.
- AW and AR to the same register in the same cycle, with old=0 and new=128'h1 -> RDATA=0, and a subsequent read returns 1.
- Assert ARESETn low mid-write-burst -> all VALID/READY outputs = 0, `csr_q` = 0, and a fresh burst after release completes with OKAY.
